// File: rtl/text_console_ctrl.sv
// Character-cell text console controller: turns a stream of ASCII/control codes into
// write strobes for a COLSxROWS character buffer, with line and full-screen clear sweeps.
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       buf_we,
  output logic [6:0] buf_x,
  output logic [4:0] buf_y,
  output logic [7:0] buf_data,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  state_t     r_state, w_state_next;
  logic       r_buf_we, w_buf_we_next;
  logic [6:0] r_buf_x, w_buf_x_next;
  logic [4:0] r_buf_y, w_buf_y_next;
  logic [7:0] r_buf_data, w_buf_data_next;
  logic [6:0] r_cur_x, w_cur_x_next;
  logic [4:0] r_cur_y, w_cur_y_next;
  logic [6:0] r_sweep_x, w_sweep_x_next;
  logic [4:0] r_sweep_y, w_sweep_y_next;
  // Set once the last sweep write is registered, so that write is still seen with busy=1.
  logic       r_sweep_done, w_sweep_done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_buf_we     <= 1'b0;
      r_buf_x      <= 7'd0;
      r_buf_y      <= 5'd0;
      r_buf_data   <= BLANK;
      r_cur_x      <= 7'd0;
      r_cur_y      <= 5'd0;
      r_sweep_x    <= 7'd0;
      r_sweep_y    <= 5'd0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_buf_we     <= w_buf_we_next;
      r_buf_x      <= w_buf_x_next;
      r_buf_y      <= w_buf_y_next;
      r_buf_data   <= w_buf_data_next;
      r_cur_x      <= w_cur_x_next;
      r_cur_y      <= w_cur_y_next;
      r_sweep_x    <= w_sweep_x_next;
      r_sweep_y    <= w_sweep_y_next;
      r_sweep_done <= w_sweep_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_buf_we_next     = 1'b0;
    w_buf_x_next      = r_buf_x;
    w_buf_y_next      = r_buf_y;
    w_buf_data_next   = r_buf_data;
    w_cur_x_next      = r_cur_x;
    w_cur_y_next      = r_cur_y;
    w_sweep_x_next    = r_sweep_x;
    w_sweep_y_next    = r_sweep_y;
    w_sweep_done_next = r_sweep_done;
    case (r_state)
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            8'h0A: begin
              w_cur_x_next = 7'd0;
              if (r_cur_y != LAST_Y) begin
                w_cur_y_next = r_cur_y + 5'd1;
              end else begin
                w_cur_y_next      = 5'd0;
                w_state_next      = CLR_LINE;
                w_sweep_x_next    = 7'd0;
                w_sweep_y_next    = 5'd0;
                w_sweep_done_next = 1'b0;
              end
            end
            8'h0D: w_cur_x_next = 7'd0;
            8'h08: begin
              if (r_cur_x != 7'd0) begin
                w_cur_x_next    = r_cur_x - 7'd1;
                w_buf_we_next   = 1'b1;
                w_buf_x_next    = r_cur_x - 7'd1;
                w_buf_y_next    = r_cur_y;
                w_buf_data_next = BLANK;
              end
            end
            8'h0C: begin
              w_cur_x_next      = 7'd0;
              w_cur_y_next      = 5'd0;
              w_state_next      = CLR_SCREEN;
              w_sweep_x_next    = 7'd0;
              w_sweep_y_next    = 5'd0;
              w_sweep_done_next = 1'b0;
            end
            default: begin
              if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                w_buf_we_next   = 1'b1;
                w_buf_x_next    = r_cur_x;
                w_buf_y_next    = r_cur_y;
                w_buf_data_next = char_data;
                if (r_cur_x != LAST_X) begin
                  w_cur_x_next = r_cur_x + 7'd1;
                end else if (r_cur_y != LAST_Y) begin
                  w_cur_x_next = 7'd0;
                  w_cur_y_next = r_cur_y + 5'd1;
                end else begin
                  w_cur_x_next      = 7'd0;
                  w_cur_y_next      = 5'd0;
                  w_state_next      = CLR_LINE;
                  w_sweep_x_next    = 7'd0;
                  w_sweep_y_next    = 5'd0;
                  w_sweep_done_next = 1'b0;
                end
              end
            end
          endcase
        end
      end
      CLR_LINE: begin
        if (r_sweep_done) begin
          w_state_next = IDLE;
        end else begin
          w_buf_we_next   = 1'b1;
          w_buf_x_next    = r_sweep_x;
          w_buf_y_next    = 5'd0;
          w_buf_data_next = BLANK;
          if (r_sweep_x == LAST_X) w_sweep_done_next = 1'b1;
          else                     w_sweep_x_next    = r_sweep_x + 7'd1;
        end
      end
      CLR_SCREEN: begin
        if (r_sweep_done) begin
          w_state_next = IDLE;
        end else begin
          w_buf_we_next   = 1'b1;
          w_buf_x_next    = r_sweep_x;
          w_buf_y_next    = r_sweep_y;
          w_buf_data_next = BLANK;
          if (r_sweep_x != LAST_X) begin
            w_sweep_x_next = r_sweep_x + 7'd1;
          end else begin
            w_sweep_x_next = 7'd0;
            if (r_sweep_y == LAST_Y) w_sweep_done_next = 1'b1;
            else                     w_sweep_y_next    = r_sweep_y + 5'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign char_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign buf_we     = r_buf_we;
  assign buf_x      = r_buf_x;
  assign buf_y      = r_buf_y;
  assign buf_data   = r_buf_data;
  assign cursor_x   = r_cur_x;
  assign cursor_y   = r_cur_y;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed-vector bench for text_console_ctrl: printable writes, cursor wrap,
// control codes, line/screen clear sweeps and reset abort.
module tb_text_console_ctrl;

  logic       clk;
  logic       reset;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       buf_we;
  logic [6:0] buf_x;
  logic [4:0] buf_y;
  logic [7:0] buf_data;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  int n_total;
  int n_bad;

  text_console_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .buf_we     (buf_we),
    .buf_x      (buf_x),
    .buf_y      (buf_y),
    .buf_data   (buf_data),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  // {ready, busy, we, x, y, data, cursor_x, cursor_y}
  wire [34:0] w_obs = {char_ready, busy, buf_we, buf_x, buf_y, buf_data, cursor_x, cursor_y};
  wire [11:0] w_cur = {cursor_x, cursor_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    @(negedge clk);
    char_valid = 1'b0;
    $display("tx char=%h cursor=(%0d,%0d) we=%0b", c, cursor_x, cursor_y, buf_we);
  endtask

  task automatic test_reset;
    logic [34:0] exp;
    exp = {1'b1, 1'b0, 1'b0, 7'd0, 5'd0, 8'h20, 7'd0, 5'd0};
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL reset_hold got=%h want=%h", w_obs, exp); end
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL reset_release got=%h want=%h", w_obs, exp); end
  endtask

  task automatic test_single_char;
    logic [34:0] exp;
    send_char(8'h41);
    exp = {1'b1, 1'b0, 1'b1, 7'd0, 5'd0, 8'h41, 7'd1, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL single_write got=%h want=%h", w_obs, exp); end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 7'd0, 5'd0, 8'h41, 7'd1, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL single_we_drop got=%h want=%h", w_obs, exp); end
  endtask

  task automatic test_back_to_back;
    logic [34:0] exp;
    send_char(8'h0D);
    exp = {1'b1, 1'b0, 1'b0, 7'd0, 5'd0, 8'h41, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL cr_row0 got=%h want=%h", w_obs, exp); end
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = 8'h21;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i < 79) exp = {1'b1, 1'b0, 1'b1, 7'(i), 5'd0, 8'(33 + i), 7'(i + 1), 5'd0};
      else        exp = {1'b1, 1'b0, 1'b1, 7'(i), 5'd0, 8'(33 + i), 7'd0, 5'd1};
      n_total++;
      if (w_obs !== exp) begin n_bad++; $display("FAIL stream_%0d got=%h want=%h", i, w_obs, exp); end
      if (i < 79) char_data = 8'(34 + i);
      else        char_valid = 1'b0;
    end
  endtask

  task automatic test_wrap;
    logic [34:0] exp;
    for (int i = 0; i < 23; i++) send_char(8'h0A);
    n_total++;
    if (w_cur !== {7'd0, 5'd24}) begin n_bad++; $display("FAIL lf_to_row24 got=%h want=%h", w_cur, {7'd0, 5'd24}); end
    for (int i = 0; i < 79; i++) send_char(8'h78);
    exp = {1'b1, 1'b0, 1'b1, 7'd78, 5'd24, 8'h78, 7'd79, 5'd24};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL fill_row24 got=%h want=%h", w_obs, exp); end
    send_char(8'h5A);
    exp = {1'b0, 1'b1, 1'b1, 7'd79, 5'd24, 8'h5A, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL wrap_z got=%h want=%h", w_obs, exp); end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 7'(k), 5'd0, 8'h20, 7'd0, 5'd0};
      n_total++;
      if (w_obs !== exp) begin n_bad++; $display("FAIL wrap_line_%0d got=%h want=%h", k, w_obs, exp); end
    end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 7'd79, 5'd0, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL wrap_end got=%h want=%h", w_obs, exp); end
  endtask

  task automatic test_clear_screen;
    logic [34:0] exp;
    send_char(8'h0C);
    exp = {1'b0, 1'b1, 1'b0, 7'd79, 5'd0, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ff_entry got=%h want=%h", w_obs, exp); end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 7'(c % 80), 5'(c / 80), 8'h20, 7'd0, 5'd0};
      n_total++;
      if (w_obs !== exp) begin n_bad++; $display("FAIL ff_cell_%0d got=%h want=%h", c, w_obs, exp); end
      if (c == 1000) begin
        char_valid = 1'b1;
        char_data  = 8'h51;
      end
    end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 7'd79, 5'd24, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ff_end got=%h want=%h", w_obs, exp); end
    @(negedge clk);
    char_valid = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 7'd0, 5'd0, 8'h51, 7'd1, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ff_held_char got=%h want=%h", w_obs, exp); end
  endtask

  task automatic test_controls;
    logic [34:0] exp;
    send_char(8'h0D);
    for (int i = 0; i < 3; i++) send_char(8'h0A);
    for (int i = 0; i < 5; i++) send_char(8'h62);
    exp = {1'b1, 1'b0, 1'b1, 7'd4, 5'd3, 8'h62, 7'd5, 5'd3};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL pos_5_3 got=%h want=%h", w_obs, exp); end
    send_char(8'h08);
    exp = {1'b1, 1'b0, 1'b1, 7'd4, 5'd3, 8'h20, 7'd4, 5'd3};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL bs_5_3 got=%h want=%h", w_obs, exp); end
    send_char(8'h0D);
    exp = {1'b1, 1'b0, 1'b0, 7'd4, 5'd3, 8'h20, 7'd0, 5'd3};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL cr_row3 got=%h want=%h", w_obs, exp); end
    send_char(8'h08);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL bs_at_x0 got=%h want=%h", w_obs, exp); end
    send_char(8'h07);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ignore_07 got=%h want=%h", w_obs, exp); end
    send_char(8'h7F);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ignore_7f got=%h want=%h", w_obs, exp); end
    send_char(8'hFF);
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL ignore_ff got=%h want=%h", w_obs, exp); end

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) send_char(8'h0A);
    for (int i = 0; i < 10; i++) send_char(8'h63);
    send_char(8'h0D);
    exp = {1'b1, 1'b0, 1'b0, 7'd9, 5'd2, 8'h63, 7'd0, 5'd2};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL cr_10_2 got=%h want=%h", w_obs, exp); end
    for (int i = 0; i < 22; i++) send_char(8'h0A);
    n_total++;
    if (w_cur !== {7'd0, 5'd24}) begin n_bad++; $display("FAIL lf_row24b got=%h want=%h", w_cur, {7'd0, 5'd24}); end
    send_char(8'h0A);
    exp = {1'b0, 1'b1, 1'b0, 7'd9, 5'd2, 8'h63, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL lf_wrap got=%h want=%h", w_obs, exp); end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, 7'(k), 5'd0, 8'h20, 7'd0, 5'd0};
      n_total++;
      if (w_obs !== exp) begin n_bad++; $display("FAIL lf_line_%0d got=%h want=%h", k, w_obs, exp); end
    end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 7'd79, 5'd0, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL lf_end got=%h want=%h", w_obs, exp); end
  endtask

  task automatic test_reset_mid_sweep;
    logic [34:0] exp;
    send_char(8'h0C);
    for (int c = 0; c <= 500; c++) @(negedge clk);
    exp = {1'b0, 1'b1, 1'b1, 7'd20, 5'd6, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL abort_cell500 got=%h want=%h", w_obs, exp); end
    reset = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 1'b0, 7'd0, 5'd0, 8'h20, 7'd0, 5'd0};
    n_total++;
    if (w_obs !== exp) begin n_bad++; $display("FAIL abort_now got=%h want=%h", w_obs, exp); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (w_obs !== exp) begin n_bad++; $display("FAIL abort_after_%0d got=%h want=%h", i, w_obs, exp); end
    end
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    test_reset;
    test_single_char;
    test_back_to_back;
    test_wrap;
    test_clear_screen;
    test_controls;
    test_reset_mid_sweep;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
